// File: rtl/memory_arbiter_pkg.sv
// Shared types for the RAM arbiter: word/RAM-state types, FSM encodings and a
// completion helper.
package memory_arbiter_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {
    FREE   = 2'd0,
    BUSY   = 2'd1,
    ACCESS = 2'd2,
    ERROR  = 2'd3
  } ramstate_t;

  typedef logic [1:0] arb_state_t;

  localparam arb_state_t IDLE = 2'd0;
  localparam arb_state_t IGNT = 2'd1;
  localparam arb_state_t DGNT = 2'd2;

  // ERROR completes a transaction just like ACCESS; only the data differs.
  function automatic logic ram_done(input ramstate_t s);
    return (s == ACCESS) || (s == ERROR);
  endfunction

endpackage

// File: rtl/memory_arbiter_if.sv
// Bundle of the fetch, data and RAM-side signals around the arbiter, with one
// modport per party.
interface memory_arbiter_if;
  import memory_arbiter_pkg::*;

  logic      iREN;
  word_t     iaddr;
  logic      ihit;
  word_t     iload;
  logic      dREN;
  logic      dWEN;
  word_t     daddr;
  word_t     dstore;
  logic      dhit;
  word_t     dload;
  logic      ramREN;
  logic      ramWEN;
  word_t     ramaddr;
  word_t     ramstore;
  word_t     ramload;
  ramstate_t ramstate;
  logic      ramerr;

  modport arbiter (
    input  iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
    output ihit, iload, dhit, dload, ramREN, ramWEN, ramaddr, ramstore, ramerr
  );

  modport caches (
    output iREN, iaddr, dREN, dWEN, daddr, dstore,
    input  ihit, iload, dhit, dload, ramerr
  );

  modport ram (
    input  ramREN, ramWEN, ramaddr, ramstore,
    output ramload, ramstate
  );

endinterface

// File: rtl/memory_arbiter.sv
// Single-port RAM arbiter: data has priority over instruction fetch, with a
// saturating starvation counter that forces a fetch grant after STARVE_MAX data grants.
module memory_arbiter
  import memory_arbiter_pkg::*;
#(
  parameter int unsigned STARVE_MAX = 4,
  parameter int unsigned CNT_W      = 4
) (
  input  logic              CLK,
  input  logic              RST,
  memory_arbiter_if.arbiter bus
);

  localparam logic [CNT_W-1:0] STARVE_LIM = CNT_W'(STARVE_MAX);

  arb_state_t       state_q, state_d;
  logic [CNT_W-1:0] starve_q, starve_d;
  word_t            addr_q, addr_d;
  word_t            store_q, store_d;
  logic             wr_q, wr_d;
  logic             d_req_s, done_s, err_s, take_d_s;

  assign d_req_s  = bus.dREN | bus.dWEN;
  assign done_s   = ram_done(bus.ramstate);
  assign err_s    = (bus.ramstate == ERROR);
  assign take_d_s = d_req_s & (~bus.iREN | (starve_q < STARVE_LIM));

  // Arbitrate in IDLE; leave a grant state on completion or when the owner drops its request.
  always_comb begin
    state_d  = state_q;
    starve_d = starve_q;
    addr_d   = addr_q;
    store_d  = store_q;
    wr_d     = wr_q;
    case (state_q)
      IDLE: begin
        if (take_d_s) begin
          state_d = DGNT;
          addr_d  = bus.daddr;
          store_d = bus.dstore;
          wr_d    = bus.dWEN;
          if (bus.iREN) begin
            if (starve_q < STARVE_LIM) begin
              starve_d = starve_q + CNT_W'(1);
            end else begin
              starve_d = starve_q;
            end
          end else begin
            starve_d = '0;
          end
        end else if (bus.iREN) begin
          state_d  = IGNT;
          addr_d   = bus.iaddr;
          store_d  = 32'h0000_0000;
          wr_d     = 1'b0;
          starve_d = '0;
        end else begin
          state_d = IDLE;
        end
      end
      IGNT: begin
        if (!bus.iREN || done_s) begin
          state_d = IDLE;
        end else begin
          state_d = IGNT;
        end
      end
      DGNT: begin
        if (!d_req_s || done_s) begin
          state_d = IDLE;
        end else begin
          state_d = DGNT;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // RAM drive comes from the latched grant; hits are combinational on the completing cycle.
  always_comb begin
    bus.ihit     = 1'b0;
    bus.iload    = 32'h0000_0000;
    bus.dhit     = 1'b0;
    bus.dload    = 32'h0000_0000;
    bus.ramREN   = 1'b0;
    bus.ramWEN   = 1'b0;
    bus.ramaddr  = 32'h0000_0000;
    bus.ramstore = 32'h0000_0000;
    bus.ramerr   = 1'b0;
    case (state_q)
      IGNT: begin
        bus.ramREN  = 1'b1;
        bus.ramaddr = addr_q;
        if (bus.iREN && done_s) begin
          bus.ihit   = 1'b1;
          bus.ramerr = err_s;
          bus.iload  = err_s ? 32'h0000_0000 : bus.ramload;
        end else begin
          bus.ihit = 1'b0;
        end
      end
      DGNT: begin
        bus.ramREN   = ~wr_q;
        bus.ramWEN   = wr_q;
        bus.ramaddr  = addr_q;
        bus.ramstore = wr_q ? store_q : 32'h0000_0000;
        if (d_req_s && done_s) begin
          bus.dhit   = 1'b1;
          bus.ramerr = err_s;
          bus.dload  = err_s ? 32'h0000_0000 : bus.ramload;
        end else begin
          bus.dhit = 1'b0;
        end
      end
      default: bus.ramREN = 1'b0;
    endcase
  end

  // FSM state, starvation count and grant latches.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q  <= IDLE;
      starve_q <= '0;
      addr_q   <= 32'h0000_0000;
      store_q  <= 32'h0000_0000;
      wr_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      starve_q <= starve_d;
      addr_q   <= addr_d;
      store_q  <= store_d;
      wr_q     <= wr_d;
    end
  end

endmodule

// File: tb/tb_memory_arbiter.sv
// Self-checking bench for memory_arbiter: constant vector table, directed
// corner-case sequences, then randomized traffic against a transaction-level model.
module tb_memory_arbiter;
  import memory_arbiter_pkg::*;

  localparam int STARVE = 4;
  localparam int NV     = 7;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  memory_arbiter_if bus();

  memory_arbiter #(.STARVE_MAX(STARVE), .CNT_W(4)) dut (
    .CLK (clk),
    .RST (rst),
    .bus (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic      iren;
    logic      dren;
    logic      dwen;
    word_t     addr;
    word_t     store;
    int        waits;
    ramstate_t fin;
    word_t     rload;
    logic      exp_i;
    logic      exp_wen;
    word_t     exp_store;
    word_t     exp_load;
    logic      exp_err;
  } vec_t;

  vec_t  vt [NV];
  word_t mem [word_t];

  task automatic chk1(input string nm, input logic act, input logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b expected %b at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic chk32(input string nm, input word_t act, input word_t exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  task automatic clear_inputs();
    bus.iREN     = 1'b0;
    bus.iaddr    = 32'h0;
    bus.dREN     = 1'b0;
    bus.dWEN     = 1'b0;
    bus.daddr    = 32'h0;
    bus.dstore   = 32'h0;
    bus.ramload  = 32'h0;
    bus.ramstate = FREE;
  endtask

  task automatic chk_idle(input string nm);
    chk1 ({nm, "_ramREN"}, bus.ramREN, 1'b0);
    chk1 ({nm, "_ramWEN"}, bus.ramWEN, 1'b0);
    chk1 ({nm, "_ihit"}, bus.ihit, 1'b0);
    chk1 ({nm, "_dhit"}, bus.dhit, 1'b0);
    chk1 ({nm, "_ramerr"}, bus.ramerr, 1'b0);
    chk32({nm, "_ramaddr"}, bus.ramaddr, 32'h0);
    chk32({nm, "_ramstore"}, bus.ramstore, 32'h0);
    chk32({nm, "_iload"}, bus.iload, 32'h0);
    chk32({nm, "_dload"}, bus.dload, 32'h0);
  endtask

  task automatic do_reset();
    cyc();
    rst = 1'b1;
    clear_inputs();
    #1;
    chk_idle("reset");
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    smp();
    chk_idle("post_reset");
  endtask

  function automatic word_t mem_rd(input word_t a);
    if (mem.exists(a)) return mem[a];
    else return a ^ 32'h5A5A_0000;
  endfunction

  function automatic word_t rand_addr();
    word_t a;
    a = word_t'($urandom_range(0, 15)) << 2;
    return a;
  endfunction

  // Transaction-level reference state for the random phase.
  int    m_kind;   // 0 none, 1 fetch, 2 data
  int    m_cnt;
  word_t m_addr;
  word_t m_store;
  logic  m_wr;
  logic  ih_seen, dh_seen;
  int    ram_wait;
  logic  ram_busy;

  initial begin
    rst = 1'b1;
    clear_inputs();

    //           iren  dren  dwen  addr         store         w  fin     rload         exp_i exp_wen exp_store     exp_load      err
    vt[0] = '{1'b1, 1'b0, 1'b0, 32'h0000_0010, 32'h0,        0, ACCESS, 32'h1111_0000, 1'b1, 1'b0, 32'h0,        32'h1111_0000, 1'b0};
    vt[1] = '{1'b1, 1'b0, 1'b0, 32'h0000_0014, 32'h0,        2, ACCESS, 32'h2222_3333, 1'b1, 1'b0, 32'h0,        32'h2222_3333, 1'b0};
    vt[2] = '{1'b0, 1'b1, 1'b0, 32'h0000_0100, 32'hFFFF_0000, 1, ACCESS, 32'h3333_4444, 1'b0, 1'b0, 32'h0,        32'h3333_4444, 1'b0};
    vt[3] = '{1'b0, 1'b0, 1'b1, 32'h0000_0200, 32'h1234_5678, 0, ACCESS, 32'h0,         1'b0, 1'b1, 32'h1234_5678, 32'h0,        1'b0};
    vt[4] = '{1'b0, 1'b1, 1'b0, 32'h0000_0300, 32'h0,        1, ERROR,  32'hFFFF_FFFF, 1'b0, 1'b0, 32'h0,        32'h0,        1'b1};
    vt[5] = '{1'b0, 1'b1, 1'b1, 32'h0000_0204, 32'hCAFE_0001, 1, ACCESS, 32'h0,         1'b0, 1'b1, 32'hCAFE_0001, 32'h0,        1'b0};
    vt[6] = '{1'b1, 1'b0, 1'b0, 32'h0000_0018, 32'h0,        0, ERROR,  32'h7777_7777, 1'b1, 1'b0, 32'h0,        32'h0,        1'b1};

    do_reset();

    // Single-requester transactions from the table.
    for (int v = 0; v < NV; v++) begin
      cyc();
      bus.iREN = vt[v].iren;
      bus.iaddr = vt[v].iren ? vt[v].addr : 32'h0;
      bus.dREN = vt[v].dren;
      bus.dWEN = vt[v].dwen;
      bus.daddr = (vt[v].dren | vt[v].dwen) ? vt[v].addr : 32'h0;
      bus.dstore = vt[v].store;
      bus.ramstate = FREE;
      smp();
      chk1($sformatf("v%0d_req_idle", v), bus.ramREN | bus.ramWEN, 1'b0);
      for (int c = 1; c <= vt[v].waits + 1; c++) begin
        cyc();
        bus.ramstate = (c <= vt[v].waits) ? BUSY : vt[v].fin;
        bus.ramload  = (c <= vt[v].waits) ? 32'hBAD0_0000 : vt[v].rload;
        smp();
        if (c == 1) begin
          chk1 ($sformatf("v%0d_ramREN", v), bus.ramREN, ~vt[v].exp_wen);
          chk1 ($sformatf("v%0d_ramWEN", v), bus.ramWEN, vt[v].exp_wen);
          chk32($sformatf("v%0d_ramaddr", v), bus.ramaddr, vt[v].addr);
          chk32($sformatf("v%0d_ramstore", v), bus.ramstore, vt[v].exp_store);
        end
        if (c <= vt[v].waits) begin
          chk1($sformatf("v%0d_wait_nohit", v), bus.ihit | bus.dhit, 1'b0);
        end else begin
          chk1($sformatf("v%0d_ihit", v), bus.ihit, vt[v].exp_i);
          chk1($sformatf("v%0d_dhit", v), bus.dhit, ~vt[v].exp_i);
          chk1($sformatf("v%0d_ramerr", v), bus.ramerr, vt[v].exp_err);
          if (!vt[v].exp_wen)
            chk32($sformatf("v%0d_load", v), vt[v].exp_i ? bus.iload : bus.dload, vt[v].exp_load);
        end
      end
      cyc();
      clear_inputs();
      smp();
      chk1($sformatf("v%0d_back_idle", v), bus.ramREN | bus.ramWEN, 1'b0);
    end

    // Simultaneous fetch and data, two-wait RAM: data first, fetch after one IDLE cycle.
    do_reset();
    cyc();
    bus.iREN = 1'b1; bus.iaddr = 32'h0;
    bus.dREN = 1'b1; bus.daddr = 32'h100;
    smp();
    chk1("sim_c0_idle", bus.ramREN | bus.ramWEN, 1'b0);
    cyc(); bus.ramstate = BUSY; smp();
    chk1("sim_c1_ren", bus.ramREN, 1'b1);
    chk32("sim_c1_addr", bus.ramaddr, 32'h100);
    chk1("sim_c1_dhit", bus.dhit, 1'b0);
    cyc(); smp();
    chk1("sim_c2_dhit", bus.dhit, 1'b0);
    cyc(); bus.ramstate = ACCESS; bus.ramload = 32'hDEAD_BEEF; smp();
    chk1("sim_c3_dhit", bus.dhit, 1'b1);
    chk32("sim_c3_dload", bus.dload, 32'hDEAD_BEEF);
    chk1("sim_c3_ihit", bus.ihit, 1'b0);
    cyc(); bus.dREN = 1'b0; bus.ramstate = ACCESS; smp();
    chk1("sim_c4_idle", bus.ramREN | bus.ramWEN | bus.dhit | bus.ihit, 1'b0);
    cyc(); bus.ramstate = BUSY; smp();
    chk1("sim_c5_ren", bus.ramREN, 1'b1);
    chk32("sim_c5_addr", bus.ramaddr, 32'h0);
    cyc(); smp();
    chk1("sim_c6_ihit", bus.ihit, 1'b0);
    cyc(); bus.ramstate = ACCESS; bus.ramload = 32'hCAFE_F00D; smp();
    chk1("sim_c7_ihit", bus.ihit, 1'b1);
    chk32("sim_c7_iload", bus.iload, 32'hCAFE_F00D);

    // Starvation: both held, zero-wait RAM -> four data hits, one fetch, then data again.
    do_reset();
    begin
      int   nd_before;
      int   next_kind;
      logic got_i;
      nd_before = 0;
      next_kind = 0;
      got_i     = 1'b0;
      cyc();
      bus.iREN = 1'b1; bus.iaddr = 32'h80;
      bus.dREN = 1'b1; bus.daddr = 32'h400;
      bus.ramstate = ACCESS; bus.ramload = 32'h55;
      for (int c = 0; c < 40; c++) begin
        smp();
        if (bus.ihit) begin
          if (!got_i) got_i = 1'b1;
          else if (next_kind == 0) next_kind = 2;
        end else if (bus.dhit) begin
          if (!got_i) nd_before++;
          else if (next_kind == 0) next_kind = 1;
        end
        cyc();
        bus.daddr = bus.daddr + 32'h4;
      end
      chk32("starve_dhits_before_ihit", word_t'(nd_before), 32'd4);
      chk1("starve_ihit_seen", got_i, 1'b1);
      chk32("starve_data_resumes", word_t'(next_kind), 32'd1);
    end

    // Abort: fetch dropped while RAM is busy, then a data read proceeds normally.
    do_reset();
    cyc(); bus.iREN = 1'b1; bus.iaddr = 32'h44; smp();
    cyc(); bus.ramstate = BUSY; smp();
    chk1("abort_c1_ren", bus.ramREN, 1'b1);
    cyc(); bus.iREN = 1'b0; smp();
    chk1("abort_c2_ihit", bus.ihit, 1'b0);
    cyc(); bus.ramstate = ACCESS; bus.ramload = 32'h99; smp();
    chk1("abort_c3_ren", bus.ramREN, 1'b0);
    chk1("abort_c3_ihit", bus.ihit, 1'b0);
    cyc(); bus.dREN = 1'b1; bus.daddr = 32'h500; bus.ramload = 32'hABCD_0123; smp();
    chk1("abort_c4_ihit", bus.ihit, 1'b0);
    cyc(); smp();
    chk1("abort_c5_dhit", bus.dhit, 1'b1);
    chk32("abort_c5_addr", bus.ramaddr, 32'h500);
    chk32("abort_c5_dload", bus.dload, 32'hABCD_0123);

    // Reset mid-write: RAM enables and hit must drop immediately.
    do_reset();
    cyc(); bus.dWEN = 1'b1; bus.daddr = 32'h40; bus.dstore = 32'hA5A5_A5A5; smp();
    cyc(); bus.ramstate = BUSY; smp();
    chk1("rstw_c1_wen", bus.ramWEN, 1'b1);
    chk32("rstw_c1_addr", bus.ramaddr, 32'h40);
    cyc();
    bus.ramstate = ACCESS;
    #2;
    rst = 1'b1;
    #1;
    chk1("rstw_wen_async", bus.ramWEN, 1'b0);
    chk1("rstw_dhit_async", bus.dhit, 1'b0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    clear_inputs();
    smp();
    chk_idle("rstw_after");

    // Randomized traffic against the transaction-level model.
    do_reset();
    m_kind = 0; m_cnt = 0; m_addr = 32'h0; m_store = 32'h0; m_wr = 1'b0;
    ih_seen = 1'b0; dh_seen = 1'b0; ram_wait = 0; ram_busy = 1'b0;
    for (int t = 0; t < 3000; t++) begin
      logic  en, done, err, exp_ih, exp_dh, pi, pd;
      int    k;
      cyc();
      if (ih_seen || !bus.iREN) begin
        bus.iREN  = ($urandom_range(0, 1) == 1);
        bus.iaddr = rand_addr();
      end else if ($urandom_range(0, 3) == 0) begin
        bus.iaddr = rand_addr();
      end
      if (dh_seen || !(bus.dREN | bus.dWEN)) begin
        k = $urandom_range(0, 5);
        bus.dREN   = (k == 2) || (k == 3) || (k == 5);
        bus.dWEN   = (k >= 4);
        bus.daddr  = rand_addr();
        bus.dstore = $urandom();
      end else if ($urandom_range(0, 3) == 0) begin
        bus.daddr  = rand_addr();
        bus.dstore = $urandom();
      end
      if (bus.ramREN || bus.ramWEN) begin
        if (!ram_busy) begin
          ram_busy = 1'b1;
          ram_wait = $urandom_range(0, 2);
        end
        if (ram_wait == 0) begin
          bus.ramstate = ($urandom_range(0, 7) == 0) ? ERROR : ACCESS;
          bus.ramload  = mem_rd(bus.ramaddr);
          ram_busy     = 1'b0;
        end else begin
          bus.ramstate = BUSY;
          bus.ramload  = $urandom();
          ram_wait--;
        end
      end else begin
        ram_busy     = 1'b0;
        bus.ramstate = ramstate_t'($urandom_range(0, 3));
        bus.ramload  = $urandom();
      end
      smp();

      en     = bus.ramREN | bus.ramWEN;
      done   = (bus.ramstate == ACCESS) || (bus.ramstate == ERROR);
      err    = (bus.ramstate == ERROR);
      exp_ih = (m_kind == 1) && done;
      exp_dh = (m_kind == 2) && done;
      chk1("rnd_en", en, m_kind != 0);
      if (m_kind != 0) begin
        chk1 ("rnd_ramWEN", bus.ramWEN, (m_kind == 2) && m_wr);
        chk32("rnd_ramaddr", bus.ramaddr, m_addr);
        chk32("rnd_ramstore", bus.ramstore, ((m_kind == 2) && m_wr) ? m_store : 32'h0);
      end
      chk1 ("rnd_ihit", bus.ihit, exp_ih);
      chk1 ("rnd_dhit", bus.dhit, exp_dh);
      chk1 ("rnd_ramerr", bus.ramerr, (exp_ih || exp_dh) && err);
      chk32("rnd_iload", bus.iload, (exp_ih && !err) ? mem_rd(m_addr) : 32'h0);
      if (!(exp_dh && m_wr))
        chk32("rnd_dload", bus.dload, (exp_dh && !err) ? mem_rd(m_addr) : 32'h0);

      ih_seen = exp_ih;
      dh_seen = exp_dh;
      pi = bus.iREN;
      pd = bus.dREN | bus.dWEN;
      if (m_kind != 0 && done) begin
        if (m_kind == 2 && m_wr && !err) mem[m_addr] = m_store;
        m_kind = 0;
      end else if (m_kind == 0) begin
        if (pd && (!pi || m_cnt < STARVE)) begin
          m_kind  = 2;
          m_addr  = bus.daddr;
          m_store = bus.dstore;
          m_wr    = bus.dWEN;
          m_cnt   = pi ? ((m_cnt < STARVE) ? m_cnt + 1 : STARVE) : 0;
        end else if (pi) begin
          m_kind = 1;
          m_addr = bus.iaddr;
          m_wr   = 1'b0;
          m_cnt  = 0;
        end
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
